run: RTL and testbench

RUN -- requirements
Module: run

---
 rtl/run_pkg.sv | 11 +
 rtl/run.sv | 60 ++++++
 tb/tb_run.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/run_pkg.sv
// Shared constants for the run register file.
//   DATA_W   : register / data width in bits
//   ADDR_W   : register address width
//   NUM_REGS : number of registers held (2**ADDR_W)
package run_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

endpackage : run_pkg

// File: rtl/run.sv
// Register file with two combinational read ports, one synchronous write port,
// a debug monitor read port and a "last committed write" capture register.
//
// Ports:
//   clk            : sole clock, rising-edge
//   rst_n          : asynchronous active-low reset, clears all registers and memory
//   read_reg_1/2   : read port addresses
//   read_data_1/2  : read port data (combinational, no bypass of a same-cycle write)
//   write_reg      : write port address
//   reg_write      : write enable
//   write_data     : write port data
//   dbg_sel        : monitor port address
//   register_files : monitor port data
//   memory         : value of the most recent accepted write to a nonzero register
module run #(
  parameter int unsigned DATA_W = run_pkg::DATA_W,
  parameter int unsigned ADDR_W = run_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] register_files,
  output logic [DATA_W-1:0] memory
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] memory_q;
  logic              write_en;

  // Register 0 is hardwired to zero: its writes are dropped entirely.
  assign write_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      memory_q <= '0;
    end else if (write_en) begin
      regs_q[write_reg] <= write_data;
      memory_q          <= write_data;
    end
  end

  // Reads see register contents directly; a write in flight is visible only after its edge.
  assign read_data_1    = regs_q[read_reg_1];
  assign read_data_2    = regs_q[read_reg_2];
  assign register_files = regs_q[dbg_sel];
  assign memory         = memory_q;

endmodule : run

// File: tb/tb_run.sv
// Directed self-checking bench for the run register file.
module tb_run;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] read_reg_1;
  logic [AW-1:0] read_reg_2;
  logic [AW-1:0] write_reg;
  logic          reg_write;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data_1;
  logic [DW-1:0] read_data_2;
  logic [AW-1:0] dbg_sel;
  logic [DW-1:0] register_files;
  logic [DW-1:0] memory;

  int total = 0;
  int bad   = 0;

  run #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_reg_1    (read_reg_1),
    .read_reg_2    (read_reg_2),
    .write_reg     (write_reg),
    .reg_write     (reg_write),
    .write_data    (write_data),
    .read_data_1   (read_data_1),
    .read_data_2   (read_data_2),
    .dbg_sel       (dbg_sel),
    .register_files(register_files),
    .memory        (memory)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Load some state first so the reset has something to clear.
    reg_write = 1'b1; write_reg = 5'd7; write_data = 32'd123;
    tick();
    write_reg = 5'd31; write_data = 32'hffff_ffff;
    tick();
    reg_write = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_sel = i[AW-1:0];
      #0.1;
      total++;
      if (register_files !== 32'd0) begin
        bad++;
        $display("FAIL reset_sweep reg=%0d got=%h exp=%h", i, register_files, 32'd0);
      end
    end
    total++;
    if (memory !== 32'd0) begin
      bad++;
      $display("FAIL reset_memory got=%h exp=%h", memory, 32'd0);
    end
    // Write attempted while in reset is discarded.
    reg_write = 1'b1; write_reg = 5'd4; write_data = 32'd444;
    tick();
    reg_write = 1'b0;
    #3 rst_n = 1'b1;
    #1 dbg_sel = 5'd4;
    #1;
    total++;
    if (register_files !== 32'd0 || memory !== 32'd0) begin
      bad++;
      $display("FAIL reset_write_discard got=%h/%h exp=%h/%h", register_files, memory,
               32'd0, 32'd0);
    end
    tick();
  endtask

  task automatic test_write();
    reg_write = 1'b1; write_reg = 5'd1; write_data = 32'd55;
    tick();
    reg_write = 1'b0; read_reg_2 = 5'd1;
    #1;
    total++;
    if (read_data_2 !== 32'd55) begin
      bad++;
      $display("FAIL write_read2 got=%0d exp=%0d", read_data_2, 55);
    end
    total++;
    if (memory !== 32'd55) begin
      bad++;
      $display("FAIL write_memory got=%0d exp=%0d", memory, 55);
    end
  endtask

  task automatic test_no_write();
    reg_write = 1'b0; write_reg = 5'd1; write_data = 32'd99;
    tick(); tick(); tick();
    read_reg_1 = 5'd1;
    #1;
    total++;
    if (read_data_1 !== 32'd55) begin
      bad++;
      $display("FAIL nowrite_read1 got=%0d exp=%0d", read_data_1, 55);
    end
    total++;
    if (memory !== 32'd55) begin
      bad++;
      $display("FAIL nowrite_memory got=%0d exp=%0d", memory, 55);
    end
  endtask

  task automatic test_reg0();
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'd77;
    tick();
    reg_write = 1'b0; read_reg_1 = 5'd0; dbg_sel = 5'd0;
    #1;
    total++;
    if (read_data_1 !== 32'd0 || register_files !== 32'd0) begin
      bad++;
      $display("FAIL reg0_read got=%0d/%0d exp=0/0", read_data_1, register_files);
    end
    total++;
    if (memory !== 32'd55) begin
      bad++;
      $display("FAIL reg0_memory got=%0d exp=%0d", memory, 55);
    end
  endtask

  task automatic test_same_cycle();
    reg_write = 1'b1; write_reg = 5'd3; write_data = 32'd5;
    tick();
    write_data = 32'd9; read_reg_1 = 5'd3; read_reg_2 = 5'd3;
    #1;
    total++;
    if (read_data_1 !== 32'd5 || read_data_2 !== 32'd5) begin
      bad++;
      $display("FAIL same_before got=%0d/%0d exp=5/5", read_data_1, read_data_2);
    end
    tick();
    reg_write = 1'b0;
    total++;
    if (read_data_1 !== 32'd9 || read_data_2 !== 32'd9) begin
      bad++;
      $display("FAIL same_after got=%0d/%0d exp=9/9", read_data_1, read_data_2);
    end
    total++;
    if (memory !== 32'd9) begin
      bad++;
      $display("FAIL same_memory got=%0d exp=%0d", memory, 9);
    end
  endtask

  task automatic test_back_to_back();
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'hdead_beef;
    tick();
    write_reg = 5'd2; write_data = 32'h0000_1234;
    tick();
    reg_write = 1'b0; read_reg_1 = 5'd31; read_reg_2 = 5'd2; dbg_sel = 5'd3;
    #1;
    total++;
    if (read_data_1 !== 32'hdead_beef || read_data_2 !== 32'h0000_1234) begin
      bad++;
      $display("FAIL b2b_ports got=%h/%h exp=%h/%h", read_data_1, read_data_2,
               32'hdead_beef, 32'h0000_1234);
    end
    total++;
    if (register_files !== 32'd9 || memory !== 32'h0000_1234) begin
      bad++;
      $display("FAIL b2b_dbg_mem got=%h/%h exp=%h/%h", register_files, memory,
               32'd9, 32'h0000_1234);
    end
    dbg_sel = 5'd31;
    #1;
    total++;
    if (register_files !== 32'hdead_beef) begin
      bad++;
      $display("FAIL b2b_dbg31 got=%h exp=%h", register_files, 32'hdead_beef);
    end
  endtask

  task automatic test_async_reset();
    tick();
    #1 rst_n = 1'b0;
    #1;
    // Still well before the next rising edge.
    total++;
    if (read_data_1 !== 32'd0 || read_data_2 !== 32'd0 || register_files !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_reads got=%h/%h/%h exp=0/0/0", read_data_1, read_data_2,
               register_files);
    end
    total++;
    if (memory !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_memory got=%h exp=%h", memory, 32'd0);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    read_reg_1 = '0; read_reg_2 = '0; write_reg = '0;
    reg_write = 1'b0; write_data = '0; dbg_sel = '0;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    test_reset();
    test_write();
    test_no_write();
    test_reg0();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_run
